control_sequencer: RTL and testbench

Microcode control sequencer for the 8-bit bus CPU. It steps a T-state counter through fetch and execute phases, decodes the 4-bit opcode from the instruction register, and drives the active-low bus-read and bus-write enables of every bus register. It also drives the PC, ALU and halt controls. It sits directly upstream of the register file: every `*_IN_n` / `*_OUT_n` output connects to a register's bus-read / bus-write enable.

---
 rtl/control_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcode control sequencer for the 8-bit bus CPU: steps T0..T4, decodes the
// opcode and drives the active-low bus enables plus PC, ALU and halt controls.
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    i_CLOCK,
  input  logic                    i_CLEAR,
  input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
  input  logic                    i_CARRY,
  input  logic                    i_ZERO,
  output logic                    o_PC_OUT_n,
  output logic                    o_PC_IN_n,
  output logic                    o_PC_INC,
  output logic                    o_MAR_IN_n,
  output logic                    o_RAM_OUT_n,
  output logic                    o_RAM_IN_n,
  output logic                    o_IR_IN_n,
  output logic                    o_IR_OUT_n,
  output logic                    o_A_IN_n,
  output logic                    o_A_OUT_n,
  output logic                    o_B_IN_n,
  output logic                    o_ALU_OUT_n,
  output logic                    o_SUB,
  output logic                    o_FLAGS_IN_n,
  output logic                    o_OUT_IN_n,
  output logic                    o_HALT,
  output logic [2:0]              o_STEP
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'b0001;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'b0011;
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'b0100;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'b0101;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'b0110;
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'b0111;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'b1000;
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'b1111;

  step_e step_q, step_d;
  logic  halted_q, halted_d;

  logic pc_out, pc_in, pc_inc, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic a_in, a_out, b_in, alu_out, sub, flags_in, out_in, halt;

  logic is_alu_op;
  logic is_mem_op;
  assign is_alu_op = (i_OPCODE == OP_ADD) || (i_OPCODE == OP_SUB);
  assign is_mem_op = (i_OPCODE == OP_LDA) || (i_OPCODE == OP_STA);

  // Next step: instruction length decides where the counter wraps to T0.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d   = step_q;
      halted_d = 1'b1;
    end else begin
      case (step_q)
        T0: step_d = T1;
        T1: step_d = T2;
        T2: begin
          if (i_OPCODE == OP_HLT) begin
            step_d   = T2;
            halted_d = 1'b1;
          end else if (is_alu_op || is_mem_op) begin
            step_d = T3;
          end else begin
            step_d = T0;
          end
        end
        T3: begin
          if (is_alu_op) begin
            step_d = T4;
          end else begin
            step_d = T0;
          end
        end
        T4:      step_d = T0;
        default: step_d = T0;
      endcase
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge i_CLOCK) begin
    if (i_CLEAR) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Control decode; clear forces everything inactive, halt leaves only o_HALT.
  always_comb begin
    pc_out = 1'b0; pc_in = 1'b0; pc_inc = 1'b0; mar_in = 1'b0;
    ram_out = 1'b0; ram_in = 1'b0; ir_in = 1'b0; ir_out = 1'b0;
    a_in = 1'b0; a_out = 1'b0; b_in = 1'b0; alu_out = 1'b0;
    sub = 1'b0; flags_in = 1'b0; out_in = 1'b0; halt = 1'b0;
    if (i_CLEAR) begin
      halt = 1'b0;
    end else if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (step_q)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (i_OPCODE)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            OP_JMP: begin
              ir_out = 1'b1;
              pc_in  = 1'b1;
            end
            OP_JC: begin
              ir_out = i_CARRY;
              pc_in  = i_CARRY;
            end
            OP_JZ: begin
              ir_out = i_ZERO;
              pc_in  = i_ZERO;
            end
            OP_OUT: begin
              a_out  = 1'b1;
              out_in = 1'b1;
            end
            OP_HLT:  halt = 1'b1;
            default: halt = 1'b0;
          endcase
        end
        T3: begin
          if (is_alu_op) begin
            ram_out = 1'b1;
            b_in    = 1'b1;
            sub     = (i_OPCODE == OP_SUB);
          end else if (i_OPCODE == OP_LDA) begin
            ram_out = 1'b1;
            a_in    = 1'b1;
          end else if (i_OPCODE == OP_STA) begin
            a_out  = 1'b1;
            ram_in = 1'b1;
          end else begin
            halt = 1'b0;
          end
        end
        T4: begin
          if (is_alu_op) begin
            alu_out  = 1'b1;
            a_in     = 1'b1;
            flags_in = 1'b1;
            sub      = (i_OPCODE == OP_SUB);
          end else begin
            halt = 1'b0;
          end
        end
        default: halt = 1'b0;
      endcase
    end
  end

  assign o_PC_OUT_n   = ~pc_out;
  assign o_PC_IN_n    = ~pc_in;
  assign o_PC_INC     = pc_inc;
  assign o_MAR_IN_n   = ~mar_in;
  assign o_RAM_OUT_n  = ~ram_out;
  assign o_RAM_IN_n   = ~ram_in;
  assign o_IR_IN_n    = ~ir_in;
  assign o_IR_OUT_n   = ~ir_out;
  assign o_A_IN_n     = ~a_in;
  assign o_A_OUT_n    = ~a_out;
  assign o_B_IN_n     = ~b_in;
  assign o_ALU_OUT_n  = ~alu_out;
  assign o_SUB        = sub;
  assign o_FLAGS_IN_n = ~flags_in;
  assign o_OUT_IN_n   = ~out_in;
  assign o_HALT       = halt;
  assign o_STEP       = i_CLEAR ? 3'd0 : step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed per-cycle vectors are queued
// by the driver and compared at the falling edge by an independent monitor.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clr, carry, zero;
  logic [3:0] op;
  logic pc_out_n, pc_in_n, pc_inc, mar_in_n, ram_out_n, ram_in_n, ir_in_n, ir_out_n;
  logic a_in_n, a_out_n, b_in_n, alu_out_n, sub, flags_in_n, out_in_n, halt;
  logic [2:0] step;

  always #5 clk = ~clk;

  control_sequencer #(.OPCODE_WIDTH(4)) dut (
    .i_CLOCK(clk), .i_CLEAR(clr), .i_OPCODE(op), .i_CARRY(carry), .i_ZERO(zero),
    .o_PC_OUT_n(pc_out_n), .o_PC_IN_n(pc_in_n), .o_PC_INC(pc_inc),
    .o_MAR_IN_n(mar_in_n), .o_RAM_OUT_n(ram_out_n), .o_RAM_IN_n(ram_in_n),
    .o_IR_IN_n(ir_in_n), .o_IR_OUT_n(ir_out_n), .o_A_IN_n(a_in_n),
    .o_A_OUT_n(a_out_n), .o_B_IN_n(b_in_n), .o_ALU_OUT_n(alu_out_n),
    .o_SUB(sub), .o_FLAGS_IN_n(flags_in_n), .o_OUT_IN_n(out_in_n),
    .o_HALT(halt), .o_STEP(step)
  );

  // Asserted-signal masks (logical sense, independent of pin polarity).
  localparam logic [15:0] M_NONE     = 16'h0000;
  localparam logic [15:0] M_PC_OUT   = 16'h0001;
  localparam logic [15:0] M_PC_IN    = 16'h0002;
  localparam logic [15:0] M_PC_INC   = 16'h0004;
  localparam logic [15:0] M_MAR_IN   = 16'h0008;
  localparam logic [15:0] M_RAM_OUT  = 16'h0010;
  localparam logic [15:0] M_RAM_IN   = 16'h0020;
  localparam logic [15:0] M_IR_IN    = 16'h0040;
  localparam logic [15:0] M_IR_OUT   = 16'h0080;
  localparam logic [15:0] M_A_IN     = 16'h0100;
  localparam logic [15:0] M_A_OUT    = 16'h0200;
  localparam logic [15:0] M_B_IN     = 16'h0400;
  localparam logic [15:0] M_ALU_OUT  = 16'h0800;
  localparam logic [15:0] M_SUB      = 16'h1000;
  localparam logic [15:0] M_FLAGS_IN = 16'h2000;
  localparam logic [15:0] M_OUT_IN   = 16'h4000;
  localparam logic [15:0] M_HALT     = 16'h8000;

  typedef struct {
    string       name;
    logic [18:0] word;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [18:0] mon_got;
  logic [15:0] obs;
  int          nbus;
  int          checks = 0;
  int          errors = 0;

  assign obs = {halt, ~out_in_n, ~flags_in_n, sub, ~alu_out_n, ~b_in_n, ~a_out_n, ~a_in_n,
                ~ir_out_n, ~ir_in_n, ~ram_in_n, ~ram_out_n, ~mar_in_n, pc_inc, ~pc_in_n,
                ~pc_out_n};

  // Monitor: pop one expectation per cycle and check bus contention every cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_got = {step, obs};
      checks++;
      if (mon_got !== mon_e.word) begin
        errors++;
        $display("FAIL %s: got step=%0d act=%h, expected step=%0d act=%h", mon_e.name,
                 mon_got[18:16], mon_got[15:0], mon_e.word[18:16], mon_e.word[15:0]);
      end
    end
    nbus = int'(!pc_out_n) + int'(!ram_out_n) + int'(!ir_out_n) + int'(!a_out_n)
         + int'(!alu_out_n);
    checks++;
    if (nbus > 1) begin
      errors++;
      $display("FAIL bus_contention at %0t: got %0d drivers, expected at most 1", $time, nbus);
    end
  end

  task automatic cyc(input logic c, input logic [3:0] o, input logic cy, input logic z,
                     input logic [2:0] st, input logic [15:0] act, input string nm);
    clr   = c;
    op    = o;
    carry = cy;
    zero  = z;
    sb_q.push_back('{nm, {st, act}});
    @(posedge clk);
    #1;
  endtask

  // Fetch drives misleading opcodes to show they are ignored in T0/T1.
  task automatic fetch(input string nm);
    cyc(1'b0, 4'hF, 1'b1, 1'b1, 3'd0, M_PC_OUT | M_MAR_IN, {nm, "_t0"});
    cyc(1'b0, 4'h3, 1'b0, 1'b0, 3'd1, M_RAM_OUT | M_IR_IN | M_PC_INC, {nm, "_t1"});
  endtask

  initial begin
    clr = 1'b1; op = 4'h0; carry = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 4'h2, 1'b1, 1'b1, 3'd0, M_NONE, "reset0");
    cyc(1'b1, 4'h2, 1'b1, 1'b1, 3'd0, M_NONE, "reset1");

    fetch("lda");
    cyc(1'b0, 4'h1, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN, "lda_t2");
    cyc(1'b0, 4'h1, 1'b0, 1'b0, 3'd3, M_RAM_OUT | M_A_IN, "lda_t3");

    fetch("sub");
    cyc(1'b0, 4'h3, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN, "sub_t2");
    cyc(1'b0, 4'h3, 1'b0, 1'b0, 3'd3, M_RAM_OUT | M_B_IN | M_SUB, "sub_t3");
    cyc(1'b0, 4'h3, 1'b1, 1'b1, 3'd4, M_ALU_OUT | M_A_IN | M_FLAGS_IN | M_SUB, "sub_t4");

    fetch("add");
    cyc(1'b0, 4'h2, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN, "add_t2");
    cyc(1'b0, 4'h2, 1'b0, 1'b0, 3'd3, M_RAM_OUT | M_B_IN, "add_t3");
    cyc(1'b0, 4'h2, 1'b0, 1'b0, 3'd4, M_ALU_OUT | M_A_IN | M_FLAGS_IN, "add_t4");

    fetch("sta");
    cyc(1'b0, 4'h4, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN, "sta_t2");
    cyc(1'b0, 4'h4, 1'b0, 1'b0, 3'd3, M_A_OUT | M_RAM_IN, "sta_t3");

    fetch("ldi");
    cyc(1'b0, 4'h5, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_A_IN, "ldi_t2");
    fetch("jmp");
    cyc(1'b0, 4'h6, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_PC_IN, "jmp_t2");
    fetch("jc0");
    cyc(1'b0, 4'h7, 1'b0, 1'b1, 3'd2, M_NONE, "jc0_t2");
    fetch("jc1");
    cyc(1'b0, 4'h7, 1'b1, 1'b0, 3'd2, M_IR_OUT | M_PC_IN, "jc1_t2");
    fetch("jz0");
    cyc(1'b0, 4'h8, 1'b1, 1'b0, 3'd2, M_NONE, "jz0_t2");
    fetch("jz1");
    cyc(1'b0, 4'h8, 1'b0, 1'b1, 3'd2, M_IR_OUT | M_PC_IN, "jz1_t2");
    fetch("out");
    cyc(1'b0, 4'hE, 1'b0, 1'b0, 3'd2, M_A_OUT | M_OUT_IN, "out_t2");
    fetch("undef");
    cyc(1'b0, 4'hB, 1'b1, 1'b1, 3'd2, M_NONE, "undef_t2");
    fetch("nop");
    cyc(1'b0, 4'h0, 1'b1, 1'b1, 3'd2, M_NONE, "nop_t2");

    fetch("addrst");
    cyc(1'b0, 4'h2, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN, "addrst_t2");
    cyc(1'b0, 4'h2, 1'b0, 1'b0, 3'd3, M_RAM_OUT | M_B_IN, "addrst_t3");
    cyc(1'b1, 4'h2, 1'b0, 1'b0, 3'd0, M_NONE, "addrst_clear");
    fetch("after_rst");
    cyc(1'b0, 4'h5, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_A_IN, "after_rst_t2");

    fetch("hlt");
    cyc(1'b0, 4'hF, 1'b0, 1'b0, 3'd2, M_HALT, "hlt_t2");
    for (int i = 0; i < 22; i++) begin
      cyc(1'b0, 4'(i), i[0], i[1], 3'd2, M_HALT, "halted");
    end
    cyc(1'b1, 4'hF, 1'b0, 1'b0, 3'd0, M_NONE, "hlt_clear");
    fetch("resume");
    cyc(1'b0, 4'h6, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_PC_IN, "resume_t2");

    for (int i = 0; i < 1000; i++) begin
      clr   = ($urandom_range(0, 39) == 0);
      op    = 4'($urandom_range(0, 15));
      carry = 1'($urandom_range(0, 1));
      zero  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
